mannix_rd_arbiter: RTL and testbench
====================================

# mannix_rd_arbiter

Parametrised N-client read arbiter for the mannix memory farm. It replaces the fixed per-client read wiring with a single arbitrated memory read port. Clients (fcc pic/wgt, cnn pic/wgt, pool) post burst read requests. The block grants one client at a time under fixed-priority-with-anti-starvation or round-robin policy, issues the burst beat by beat, and routes returned data to the owning client.

## Interface
Parameters:
- N_CLIENTS, 5, number of read clients
- ADDR_WIDTH, 19, word address width
- DATA_WIDTH, 32, read data width
- LEN_WIDTH, 8, burst length field width (beats)
- STARVE_LIMIT, 15, lost arbitrations before a waiting client is promoted (fixed mode)

Ports (one clock; reset is asynchronous and active-low, named `clk` / `rst_n`):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- cfg_mode  in  1  0 = fixed priority, 1 = round-robin
- cfg_prio_client  in  $clog2(N_CLIENTS)  top-priority client in fixed mode
- cli_req  in  N_CLIENTS  per-client request, held until gnt
- cli_addr  in  N_CLIENTS*ADDR_WIDTH  per-client burst base address
- cli_len  in  N_CLIENTS*LEN_WIDTH  per-client burst length; 0 is treated as 1
- cli_gnt  out  N_CLIENTS  one-cycle one-hot grant pulse
- cli_rvalid  out  N_CLIENTS  one-hot data-valid to owner
- cli_rdata  out  DATA_WIDTH  shared return data
- cli_done  out  N_CLIENTS  one-cycle pulse with the last returned beat
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_WIDTH  memory read address
- mem_ready  in  1  memory accepts the beat when mem_req & mem_ready
- mem_rvalid  in  1  memory return data valid
- mem_rdata  in  DATA_WIDTH  memory return data
- busy  out  1  transaction in flight

## Operation
- FSM: IDLE -> ISSUE -> RETURN -> IDLE.
- IDLE:
  - If any cli_req is high, pick the winner and register owner, base, len.
  - Pulse cli_gnt[owner] and enter ISSUE on the same edge.
- Fixed mode winner:
  - First, the lowest-index starved client (wait counter == STARVE_LIMIT).
  - Else cfg_prio_client, if it is requesting.
  - Else the lowest-index requester.
  - cfg_prio_client >= N_CLIENTS is treated as 0.
- Round-robin winner: first requester at or after rr_ptr, searching upward with wrap. rr_ptr = owner+1 (mod N_CLIENTS) after each grant.
- Wait counters:
  - Per client, saturating at STARVE_LIMIT.
  - +1 when the client requests but another client is granted.
  - Cleared when the client is granted or its req is low.
  - Counters are maintained in both modes.
- ISSUE:
  - mem_req = 1 and mem_addr = base + issued, truncated mod 2^ADDR_WIDTH (wraps).
  - issued increments on each mem_req & mem_ready.
  - After the last beat is accepted, go to RETURN.
- Return path, valid in ISSUE and RETURN:
  - On mem_rvalid: cli_rvalid[owner] = 1, cli_rdata = mem_rdata, returned++.
  - On the beat where returned reaches len: cli_done[owner] = 1 and the FSM goes to IDLE.
  - Return data may arrive during ISSUE. If all beats return while still in ISSUE (impossible unless accepted), completion still requires all beats issued.
- mem_rvalid in IDLE is ignored; no output changes.
- Only one transaction is outstanding at a time. The owner must drop cli_req before done to avoid re-arbitration, and req sampled in IDLE after done re-arbitrates.
- cfg_mode and cfg_prio_client are sampled only at arbitration; mid-transaction changes take effect at the next grant.
- busy = (state != IDLE).

## Timing
- Reset values: all outputs 0, state IDLE, rr_ptr 0, all counters 0. cli_rdata is reset to 0 and thereafter holds the last value.
- Reset asserted mid-transaction aborts immediately: mem_req drops asynchronously and no done is issued.
- req high in cycle t (IDLE) -> cli_gnt in t+1 -> mem_req first high in t+1, with mem_addr = base.
- Issue throughput: 1 beat/cycle while mem_ready is high. mem_addr is stable while mem_req is high and mem_ready is low.
- cli_rvalid, cli_rdata and cli_done are registered: one cycle after mem_rvalid.
- Minimum turnaround: the FSM returns to IDLE in the cycle after done, and the next gnt comes 1 cycle later.

## Structure
- Package mannix_arb_pkg: the state enum (IDLE/ISSUE/RETURN) and the mode constants ARB_FIXED = 1'b0 and ARB_RR = 1'b1.
- Sub-module mannix_arb_pick: combinational winner select from req, mode, prio, rr_ptr and starved vector; outputs a one-hot winner and its index.
- Beat counters are LEN_WIDTH+1 bits wide, so len = 2^LEN_WIDTH-1 does not overflow.

## Test plan
- Single client 2 requests addr 0x100, len 4, mem_ready = 1, rvalid 2 cycles after accept -> gnt[2] at t+1; mem_addr 0x100..0x103; 4 rvalid[2] beats; done[2] with the 4th.
- Fixed mode, prio = 3, clients 0, 3, 4 request together -> grant order 3, 0, 4 (3 then lowest index).
- Fixed mode, prio = 0, client 0 re-requesting continuously, client 1 waiting -> client 1 granted after exactly 15 losses (16th arbitration).
- Round-robin, all 5 clients requesting continuously -> grants 0, 1, 2, 3, 4, 0.
- len = 0 at addr 0x7FFFF, then len 3 at 0x7FFFE -> first burst is 1 beat; second burst addresses are 0x7FFFE, 0x7FFFF, 0x00000.
- mem_ready low for 3 cycles mid-burst, then rst_n asserted in RETURN -> mem_addr held while stalled; after reset all outputs 0 and busy 0, and a fresh request is granted normally.

Source files
------------

// File: rtl/mannix_arb_pkg.sv
// mannix read arbiter shared types
// transaction state encoding and arbitration mode constants
package mannix_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RETURN = 2'd2
  } arb_state_t;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/mannix_arb_pick.sv
// mannix read arbiter winner select
// combinational pick from requests, mode, priority, rr pointer, starvation
module mannix_arb_pick
  import mannix_arb_pkg::*;
#(
  parameter int N_CLIENTS = 5,
  parameter int IW        = 3
) (
  input  logic [N_CLIENTS-1:0] i_req,
  input  logic                 i_mode,
  input  logic [IW-1:0]        i_prio,
  input  logic [IW-1:0]        i_rr_ptr,
  input  logic [N_CLIENTS-1:0] i_starved,
  output logic                 o_valid,
  output logic [N_CLIENTS-1:0] o_win_oh,
  output logic [IW-1:0]        o_win_idx
);

  logic [IW-1:0] w_prio;
  logic          w_found;

  // an out-of-range priority client falls back to client 0
  assign w_prio = (int'(i_prio) >= N_CLIENTS) ? '0 : i_prio;

  assign o_valid = |i_req;

  assign o_win_oh = o_valid ?
    ({{(N_CLIENTS-1){1'b0}}, 1'b1} << o_win_idx) : '0;

  // rr: first requester at/after pointer; fixed: starved, prio, lowest
  always_comb begin
    int j;
    j         = 0;
    w_found   = 1'b0;
    o_win_idx = '0;
    if (i_mode == ARB_RR) begin
      for (int k = 0; k < N_CLIENTS; k++) begin
        j = int'(i_rr_ptr) + k;
        if (j >= N_CLIENTS) j = j - N_CLIENTS;
        if (!w_found && i_req[j]) begin
          w_found   = 1'b1;
          o_win_idx = IW'(j);
        end
      end
    end else if (|i_starved) begin
      for (int k = N_CLIENTS - 1; k >= 0; k--) begin
        if (i_starved[k]) o_win_idx = IW'(k);
      end
    end else if (i_req[w_prio]) begin
      o_win_idx = w_prio;
    end else begin
      for (int k = N_CLIENTS - 1; k >= 0; k--) begin
        if (i_req[k]) o_win_idx = IW'(k);
      end
    end
  end

endmodule

// File: rtl/mannix_rd_arbiter.sv
// mannix memory farm read arbiter
// grants one client burst at a time and routes returned beats to it
module mannix_rd_arbiter
  import mannix_arb_pkg::*;
#(
  parameter int N_CLIENTS    = 5,
  parameter int ADDR_WIDTH   = 19,
  parameter int DATA_WIDTH   = 32,
  parameter int LEN_WIDTH    = 8,
  parameter int STARVE_LIMIT = 15
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cfg_mode,
  input  logic [$clog2(N_CLIENTS)-1:0]    cfg_prio_client,
  input  logic [N_CLIENTS-1:0]            cli_req,
  input  logic [N_CLIENTS*ADDR_WIDTH-1:0] cli_addr,
  input  logic [N_CLIENTS*LEN_WIDTH-1:0]  cli_len,
  output logic [N_CLIENTS-1:0]            cli_gnt,
  output logic [N_CLIENTS-1:0]            cli_rvalid,
  output logic [DATA_WIDTH-1:0]           cli_rdata,
  output logic [N_CLIENTS-1:0]            cli_done,
  output logic                            mem_req,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic                            mem_ready,
  input  logic                            mem_rvalid,
  input  logic [DATA_WIDTH-1:0]           mem_rdata,
  output logic                            busy
);

  localparam int IW = $clog2(N_CLIENTS);
  localparam int CW = LEN_WIDTH + 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  arb_state_t             r_state;
  logic [IW-1:0]          r_rr_ptr;
  logic [N_CLIENTS-1:0]   r_owner_oh;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [CW-1:0]          r_len;
  logic [CW-1:0]          r_issued;
  logic [CW-1:0]          r_returned;
  logic [N_CLIENTS-1:0]   r_gnt;
  logic [N_CLIENTS-1:0]   r_rvalid;
  logic [N_CLIENTS-1:0]   r_done;
  logic [DATA_WIDTH-1:0]  r_rdata;
  logic [SW-1:0]          r_wait [N_CLIENTS];

  logic                   w_win_valid;
  logic [N_CLIENTS-1:0]   w_win_oh;
  logic [IW-1:0]          w_win_idx;
  logic [N_CLIENTS-1:0]   w_starved;
  logic                   w_grant;
  logic                   w_accept;
  logic                   w_ret;
  logic                   w_last_acc;
  logic                   w_last_ret;
  logic                   w_all_issued;
  logic                   w_complete;
  logic [LEN_WIDTH-1:0]   w_len_sel;
  logic [ADDR_WIDTH-1:0]  w_addr_sel;

  mannix_arb_pick #(
    .N_CLIENTS (N_CLIENTS),
    .IW        (IW)
  ) u_pick (
    .i_req     (cli_req),
    .i_mode    (cfg_mode),
    .i_prio    (cfg_prio_client),
    .i_rr_ptr  (r_rr_ptr),
    .i_starved (w_starved),
    .o_valid   (w_win_valid),
    .o_win_oh  (w_win_oh),
    .o_win_idx (w_win_idx)
  );

  // a waiting client is starved once its loss count saturates
  always_comb begin
    w_starved = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      w_starved[i] = cli_req[i] && (r_wait[i] == SW'(STARVE_LIMIT));
    end
  end

  assign w_len_sel  = cli_len[int'(w_win_idx)*LEN_WIDTH +: LEN_WIDTH];
  assign w_addr_sel = cli_addr[int'(w_win_idx)*ADDR_WIDTH +: ADDR_WIDTH];

  assign w_grant      = (r_state == IDLE) && w_win_valid;
  assign mem_req      = (r_state == ISSUE);
  assign mem_addr     = r_base + ADDR_WIDTH'(r_issued);
  assign w_accept     = mem_req && mem_ready;
  assign w_ret        = mem_rvalid && (r_state != IDLE);
  assign w_last_acc   = w_accept && ((r_issued + CW'(1)) == r_len);
  assign w_last_ret   = w_ret && ((r_returned + CW'(1)) == r_len);
  assign w_all_issued = (r_issued == r_len) || w_last_acc;
  assign w_complete   = w_last_ret &&
                        ((r_state == RETURN) || w_all_issued);

  assign busy       = (r_state != IDLE);
  assign cli_gnt    = r_gnt;
  assign cli_rvalid = r_rvalid;
  assign cli_rdata  = r_rdata;
  assign cli_done   = r_done;

  // transaction fsm: grant, issue beats, collect returns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_owner_oh <= '0;
      r_base     <= '0;
      r_len      <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_done     <= '0;
      r_rdata    <= '0;
    end else begin
      r_gnt    <= '0;
      r_rvalid <= '0;
      r_done   <= '0;
      if (w_ret) begin
        r_rvalid <= r_owner_oh;
        r_rdata  <= mem_rdata;
        if (r_returned != r_len) r_returned <= r_returned + CW'(1);
        if (w_complete) r_done <= r_owner_oh;
      end
      unique case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_owner_oh <= w_win_oh;
            r_base     <= w_addr_sel;
            r_len      <= (w_len_sel == '0) ? CW'(1) : {1'b0, w_len_sel};
            r_issued   <= '0;
            r_returned <= '0;
            r_gnt      <= w_win_oh;
            r_rr_ptr   <= (int'(w_win_idx) == N_CLIENTS - 1) ?
                          '0 : w_win_idx + IW'(1);
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (w_accept) r_issued <= r_issued + CW'(1);
          if (w_complete) r_state <= IDLE;
          else if (w_last_acc) r_state <= RETURN;
        end
        RETURN: begin
          if (w_complete) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // per-client loss counters, saturating, kept in both modes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CLIENTS; i++) r_wait[i] <= '0;
    end else begin
      for (int i = 0; i < N_CLIENTS; i++) begin
        if (!cli_req[i]) begin
          r_wait[i] <= '0;
        end else if (w_grant) begin
          if (w_win_oh[i]) r_wait[i] <= '0;
          else if (r_wait[i] != SW'(STARVE_LIMIT))
            r_wait[i] <= r_wait[i] + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mannix_rd_arbiter.sv
// mannix read arbiter bench
// directed bursts against a fixed-latency memory model
module tb_mannix_rd_arbiter;

  localparam int N  = 5;
  localparam int AW = 19;
  localparam int DW = 32;
  localparam int LW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_mode;
  logic [2:0]      cfg_prio_client;
  logic [N-1:0]    cli_req;
  logic [N*AW-1:0] cli_addr;
  logic [N*LW-1:0] cli_len;
  logic [N-1:0]    cli_gnt;
  logic [N-1:0]    cli_rvalid;
  logic [DW-1:0]   cli_rdata;
  logic [N-1:0]    cli_done;
  logic            mem_req;
  logic [AW-1:0]   mem_addr;
  logic            mem_ready;
  logic            mem_rvalid;
  logic [DW-1:0]   mem_rdata;
  logic            busy;

  always #5 clk = ~clk;

  mannix_rd_arbiter #(
    .N_CLIENTS    (N),
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .LEN_WIDTH    (LW),
    .STARVE_LIMIT (15)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_mode        (cfg_mode),
    .cfg_prio_client (cfg_prio_client),
    .cli_req         (cli_req),
    .cli_addr        (cli_addr),
    .cli_len         (cli_len),
    .cli_gnt         (cli_gnt),
    .cli_rvalid      (cli_rvalid),
    .cli_rdata       (cli_rdata),
    .cli_done        (cli_done),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_ready       (mem_ready),
    .mem_rvalid      (mem_rvalid),
    .mem_rdata       (mem_rdata),
    .busy            (busy)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_base = 0;

  int            gnt_q[$];
  int            gnt_cyc[$];
  int            done_q[$];
  int            done_cyc[$];
  logic          done_rv[$];
  int            beat_own[$];
  logic [DW-1:0] beat_dat[$];
  logic [AW-1:0] acc_q[$];
  logic [N-1:0]  hold;

  logic          acc_v;
  logic [AW-1:0] acc_a;
  logic          d0_v, d1_v;
  logic [AW-1:0] d0_a, d1_a;

  function automatic int oh2i(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] mdat(logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {13'd0, a};
  endfunction

  function automatic logic [AW-1:0] acc_at(int k);
    if (acc_base + k < acc_q.size()) return acc_q[acc_base + k];
    return '1;
  endfunction

  function automatic logic [DW-1:0] dat_at(int k);
    if (k < beat_dat.size()) return beat_dat[k];
    return 32'hFFFF_FFFF;
  endfunction

  function automatic int int_at(int q[$], int k);
    if (k < q.size()) return q[k];
    return -1;
  endfunction

  // memory accepts are logged on the active edge
  always @(posedge clk) begin
    acc_v = rst_n && mem_req && mem_ready;
    acc_a = mem_addr;
    if (acc_v) acc_q.push_back(mem_addr);
  end

  // read data returns two edges after the accept edge
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d0_v = 1'b0;
      d1_v = 1'b0;
      d0_a = '0;
      d1_a = '0;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
    end else begin
      d1_v = d0_v;
      d1_a = d0_a;
      d0_v = acc_v;
      d0_a = acc_a;
      mem_rvalid = d1_v;
      mem_rdata  = d1_v ? mdat(d1_a) : 32'hDEAD_BEEF;
    end
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (|cli_gnt) begin
      gnt_q.push_back(oh2i(cli_gnt));
      gnt_cyc.push_back(cyc);
      cli_req = cli_req & ~(cli_gnt & ~hold);
    end
    if (|cli_rvalid) begin
      beat_own.push_back(oh2i(cli_rvalid));
      beat_dat.push_back(cli_rdata);
    end
    if (|cli_done) begin
      done_q.push_back(oh2i(cli_done));
      done_cyc.push_back(cyc);
      done_rv.push_back(cli_rvalid == cli_done);
    end
  endtask

  task automatic clear();
    gnt_q.delete();
    gnt_cyc.delete();
    done_q.delete();
    done_cyc.delete();
    done_rv.delete();
    beat_own.delete();
    beat_dat.delete();
    acc_base = acc_q.size();
  endtask

  task automatic set_cli(int i, logic [AW-1:0] a, logic [LW-1:0] l);
    cli_addr[i*AW +: AW] = a;
    cli_len[i*LW +: LW]  = l;
  endtask

  task automatic wait_done(int n, int budget, string tag);
    int k;
    k = 0;
    while (done_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    check(tag, done_q.size(), n);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    cli_req = '0;
    hold = '0;
    mem_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int zeros;
    int exp_rr[6];
    cfg_mode = 1'b0;
    cfg_prio_client = 3'd0;
    cli_req = '0;
    cli_addr = '0;
    cli_len = '0;
    mem_ready = 1'b1;
    hold = '0;
    tick();
    tick();
    check("rst_gnt", cli_gnt, 0);
    check("rst_rvalid", cli_rvalid, 0);
    check("rst_rdata", cli_rdata, 0);
    check("rst_done", cli_done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    tick();

    // single burst, client 2
    clear();
    set_cli(2, 19'h100, 8'd4);
    cli_req[2] = 1'b1;
    tick();
    check("t1_gnt", cli_gnt, 5'b00100);
    check("t1_mem_req", mem_req, 1);
    check("t1_first_addr", mem_addr, 19'h100);
    check("t1_busy", busy, 1);
    wait_done(1, 30, "t1_done_cnt");
    check("t1_idle_at_done", busy, 0);
    check("t1_acc_cnt", acc_q.size() - acc_base, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_addr%0d", i), acc_at(i), 19'h100 + i);
    check("t1_beats", beat_own.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_data%0d", i), dat_at(i),
            mdat(19'h100 + AW'(i)));
    check("t1_beat_owner", int_at(beat_own, 3), 2);
    check("t1_done_owner", int_at(done_q, 0), 2);
    check("t1_done_with_last", done_rv[0], 1);

    // fixed priority 3 with clients 0, 3, 4
    clear();
    cfg_prio_client = 3'd3;
    set_cli(0, 19'h1000, 8'd2);
    set_cli(3, 19'h3000, 8'd2);
    set_cli(4, 19'h4000, 8'd2);
    cli_req = 5'b11001;
    wait_done(3, 60, "t2_done_cnt");
    check("t2_g0", int_at(gnt_q, 0), 3);
    check("t2_g1", int_at(gnt_q, 1), 0);
    check("t2_g2", int_at(gnt_q, 2), 4);
    check("t2_acc_cnt", acc_q.size() - acc_base, 6);
    check("t2_first_addr", acc_at(0), 19'h3000);

    // starvation: client 1 wins on the 16th arbitration
    do_reset();
    clear();
    cfg_prio_client = 3'd0;
    set_cli(0, 19'h10, 8'd0);
    set_cli(1, 19'h20, 8'd0);
    hold = 5'b00001;
    cli_req = 5'b00011;
    k = 0;
    while (k < 600 && !(gnt_q.size() > 0 && gnt_q[$] == 1)) begin
      tick();
      k++;
    end
    check("t3_n_arb", gnt_q.size(), 16);
    zeros = 0;
    foreach (gnt_q[i]) if (gnt_q[i] == 0) zeros++;
    check("t3_losses", zeros, 15);
    check("t3_last", int_at(gnt_q, gnt_q.size() - 1), 1);
    check("t3_turnaround", int_at(gnt_cyc, 1) - int_at(done_cyc, 0), 1);
    cli_req[0] = 1'b0;
    hold = '0;
    wait_done(16, 50, "t3_done_cnt");
    check("t3_last_done", int_at(done_q, 15), 1);

    // round robin from reset, everyone requesting
    do_reset();
    clear();
    cfg_mode = 1'b1;
    for (int i = 0; i < N; i++) set_cli(i, AW'(19'h800 + i * 16), 8'd0);
    hold = '1;
    cli_req = '1;
    k = 0;
    while (k < 100 && gnt_q.size() < 6) begin
      tick();
      k++;
    end
    cli_req = '0;
    hold = '0;
    exp_rr = '{0, 1, 2, 3, 4, 0};
    for (int i = 0; i < 6; i++)
      check($sformatf("t4_rr%0d", i), int_at(gnt_q, i), exp_rr[i]);
    wait_done(6, 30, "t4_done_cnt");

    // zero length and address wrap
    clear();
    cfg_mode = 1'b0;
    set_cli(1, 19'h7FFFF, 8'd0);
    cli_req[1] = 1'b1;
    wait_done(1, 30, "t5a_done_cnt");
    check("t5a_acc_cnt", acc_q.size() - acc_base, 1);
    check("t5a_addr", acc_at(0), 19'h7FFFF);
    check("t5a_beats", beat_own.size(), 1);
    set_cli(1, 19'h7FFFE, 8'd3);
    cli_req[1] = 1'b1;
    wait_done(2, 30, "t5b_done_cnt");
    check("t5b_acc_cnt", acc_q.size() - acc_base, 4);
    check("t5b_addr0", acc_at(1), 19'h7FFFE);
    check("t5b_addr1", acc_at(2), 19'h7FFFF);
    check("t5b_addr2", acc_at(3), 19'h00000);
    check("t5b_data2", dat_at(3), mdat(19'h0));
    check("t5b_beats", beat_own.size(), 4);

    // stall mid burst, then reset while returning
    clear();
    set_cli(4, 19'h200, 8'd6);
    cli_req[4] = 1'b1;
    tick();
    check("t6_gnt", cli_gnt, 5'b10000);
    tick();
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t6_hold_addr%0d", i), mem_addr, 19'h202);
      check($sformatf("t6_hold_req%0d", i), mem_req, 1);
    end
    mem_ready = 1'b1;
    k = 0;
    while (k < 20 && mem_req) begin
      tick();
      k++;
    end
    check("t6_in_return", busy, 1);
    check("t6_issued", acc_q.size() - acc_base, 6);
    check("t6_no_done_yet", done_q.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_mem_req", mem_req, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_addr", mem_addr, 0);
    check("t6_rst_rdata", cli_rdata, 0);
    check("t6_rst_rvalid", cli_rvalid, 0);
    cli_req = '0;
    tick();
    tick();
    check("t6_no_done", done_q.size(), 0);
    rst_n = 1'b1;
    tick();
    clear();
    set_cli(3, 19'h40, 8'd2);
    cli_req[3] = 1'b1;
    tick();
    check("t6_new_gnt", cli_gnt, 5'b01000);
    check("t6_new_addr", mem_addr, 19'h40);
    wait_done(1, 30, "t6_new_done_cnt");
    check("t6_new_owner", int_at(done_q, 0), 3);
    check("t6_new_beats", beat_own.size(), 2);
    check("t6_new_data1", dat_at(1), mdat(19'h41));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
